// File: rtl/sram_sdp_pipe_if.sv
// sram_sdp_pipe_if: write/read/clear bus of the simple-dual-port SRAM
interface sram_sdp_pipe_if #(
  parameter int DW = 32,
  parameter int AW = 6
);
  logic            wen;
  logic [AW-1:0]   waddr;
  logic [DW/8-1:0] wmask;
  logic [DW-1:0]   data_in;
  logic            ren;
  logic [AW-1:0]   raddr;
  logic            clr;
  logic [DW-1:0]   data_out;
  logic            out_valid;
  logic            busy;
  modport master (
    output wen, waddr, wmask, data_in, ren, raddr, clr,
    input  data_out, out_valid, busy
  );
  modport slave (
    input  wen, waddr, wmask, data_in, ren, raddr, clr,
    output data_out, out_valid, busy
  );
endinterface

// File: rtl/sram_sdp_pipe.sv
// sram_sdp_pipe: parametrised simple-dual-port SRAM with byte mask, RD_LAT read pipeline and clear engine; define SRAM_SDP_BYPASS_EN to forward same-address writes to reads
module sram_sdp_pipe #(
  parameter int DW     = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = 6,
  parameter int RD_LAT = 1
) (
  input logic            clk,
  input logic            rstn,
  sram_sdp_pipe_if.slave bus
);
  localparam int NB = DW / 8;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t            state, state_n;
  logic [AW-1:0]     cnt, cnt_n;
  logic [DW-1:0]     mem [DEPTH];
  logic              busy, w_ok, r_ok, accept;
  logic [DW-1:0]     rd_word;
  logic [RD_LAT-1:0] pv;
  logic [DW-1:0]     pd [RD_LAT];
  assign busy   = state == CLEAR;
  assign w_ok   = bus.wen && !busy && ({1'b0, bus.waddr} < (AW+1)'(DEPTH));
  assign r_ok   = {1'b0, bus.raddr} < (AW+1)'(DEPTH);
  assign accept = bus.ren && !busy;
  always_comb begin
    state_n = busy ? ((cnt == AW'(DEPTH - 1)) ? IDLE : CLEAR) : (bus.clr ? CLEAR : IDLE);
    cnt_n   = busy ? cnt + 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
  // clearing owns the write port; user writes are dropped while busy
  always_ff @(posedge clk) begin
    if (busy)
      mem[cnt] <= '0;
    else if (w_ok)
      for (int i = 0; i < NB; i++)
        if (bus.wmask[i]) mem[bus.waddr][8*i +: 8] <= bus.data_in[8*i +: 8];
  end
  always_comb begin
    rd_word = r_ok ? mem[bus.raddr] : '0;
`ifdef SRAM_SDP_BYPASS_EN
    if (r_ok && w_ok && bus.waddr == bus.raddr)
      for (int i = 0; i < NB; i++)
        if (bus.wmask[i]) rd_word[8*i +: 8] = bus.data_in[8*i +: 8];
`endif
  end
  // data stages only advance with a valid token so data_out holds between reads
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pv <= '0;
      for (int k = 0; k < RD_LAT; k++) pd[k] <= '0;
    end else begin
      pv[0] <= accept;
      if (accept) pd[0] <= rd_word;
      for (int k = 1; k < RD_LAT; k++) begin
        pv[k] <= pv[k-1];
        if (pv[k-1]) pd[k] <= pd[k-1];
      end
    end
  end
  assign bus.data_out  = pd[RD_LAT-1];
  assign bus.out_valid = pv[RD_LAT-1];
  assign bus.busy      = busy;
endmodule
